des_round_ctrl: RTL and testbench

Iterative DES round sequencer. It accepts one block-operation request, sequences the 16 Feistel rounds of the shared round datapath (f(R,K) with its registered S-box stage), and runs the C/D key schedule (post-PC1, pre-PC2). It sits between the cipher top-level request interface and the round datapath/PC2 logic. It supports both encrypt and decrypt key order.

---
 rtl/des_pkg.sv | 26 ++
 rtl/des_cd_rotate.sv | 30 +++
 rtl/des_round_ctrl.sv | 127 ++++++++++++
 tb/tb_des_round_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared types and constants for the iterative DES round sequencer:
// key-schedule shift table, controller state encoding and the C/D pair.
package des_pkg;

   localparam int DES_ROUNDS = 16;
   localparam int DES_HALF_W = 28;

   // Left-rotation amount applied to C and D before each round's PC2.
   localparam logic [1:0] SHIFT [DES_ROUNDS] = '{
      2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
   };

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic [DES_HALF_W-1:0] c;
      logic [DES_HALF_W-1:0] d;
   } cd_t;

endpackage

// File: rtl/des_cd_rotate.sv
// Combinational key-schedule rotator: C and D halves rotate independently
// by 0, 1 or 2 positions, left for encrypt or right for decrypt.
module des_cd_rotate
   import des_pkg::*;
(
   input  cd_t        cd_in,
   input  logic [1:0] amount,
   input  logic       right,
   output cd_t        cd_out
);

   function automatic logic [DES_HALF_W-1:0] rot28(input logic [DES_HALF_W-1:0] x,
                                                   input logic [1:0] n,
                                                   input logic r);
      logic [DES_HALF_W-1:0] y;
      unique case (n)
         2'd1:    y = r ? {x[0], x[27:1]}   : {x[26:0], x[27]};
         2'd2:    y = r ? {x[1:0], x[27:2]} : {x[25:0], x[27:26]};
         default: y = x;
      endcase
      return y;
   endfunction

   always_comb begin
      cd_out   = cd_in;
      cd_out.c = rot28(cd_in.c, amount, right);
      cd_out.d = rot28(cd_in.d, amount, right);
   end

endmodule

// File: rtl/des_round_ctrl.sv
// Iterative DES round sequencer: accepts one block request, paces the 16
// Feistel rounds of the shared datapath and steps the C/D key schedule.
//
// Handshake: start is accepted on any clock where ready=1 (state IDLE);
// start while ready=0 is ignored. load_data, round_en and done are
// single-cycle pulses; abort returns to IDLE and suppresses them.
module des_round_ctrl
   import des_pkg::*;
#(
   parameter int ROUND_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        decrypt,
   input  logic [55:0] key_cd,
   input  logic        abort,
   output logic        ready,
   output logic        busy,
   output logic        load_data,
   output logic        round_en,
   output logic [3:0]  round_idx,
   output logic        last_round,
   output logic [55:0] subkey_cd,
   output logic        done,
   output state_t      dbg_state
);

   state_t     state, state_nxt;
   logic [2:0] cnt;
   logic [3:0] idx;
   logic       mode_dec;
   cd_t        cd_reg, rot_in, rot_out;
   logic [1:0] rot_amt;
   logic       rot_right;
   logic       accept;
   logic       round_end;

   assign accept    = (state == IDLE) && start;
   assign round_end = (state == ROUND) && (cnt == 3'(ROUND_CYCLES - 1));

   // One rotator serves both the accept-time pre-rotation and per-round steps.
   always_comb begin
      if (state == IDLE) begin
         rot_in    = key_cd;
         rot_amt   = decrypt ? 2'd0 : 2'd1;
         rot_right = 1'b0;
      end else begin
         rot_in    = cd_reg;
         rot_amt   = mode_dec ? SHIFT[4'd15 - idx] : SHIFT[idx + 4'd1];
         rot_right = mode_dec;
      end
   end

   des_cd_rotate u_rotate (
      .cd_in  (rot_in),
      .amount (rot_amt),
      .right  (rot_right),
      .cd_out (rot_out)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  if (start) state_nxt = LOAD;
         LOAD:  state_nxt = ROUND;
         ROUND: if (round_end && idx == 4'd15) state_nxt = DONE;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (abort && state != IDLE) state_nxt = IDLE;
   end

   always_comb begin
      ready      = (state == IDLE);
      busy       = ~ready;
      load_data  = (state == LOAD) && !abort;
      round_en   = round_end && !abort;
      done       = (state == DONE) && !abort;
      last_round = (state == ROUND) && (idx == 4'd15);
      round_idx  = idx;
      subkey_cd  = cd_reg;
      dbg_state  = state;
   end

   // Round counters and key schedule; cd_reg only moves at accept or round commit.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt      <= '0;
         idx      <= '0;
         mode_dec <= 1'b0;
         cd_reg   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  mode_dec <= decrypt;
                  cd_reg   <= rot_out;
                  cnt      <= '0;
               end
            end
            LOAD: begin
               idx <= '0;
               cnt <= '0;
            end
            ROUND: begin
               if (round_end) begin
                  cnt <= '0;
                  if (idx != 4'd15 && !abort) begin
                     idx    <= idx + 4'd1;
                     cd_reg <= rot_out;
                  end
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_des_round_ctrl.sv
// Bench for des_round_ctrl: table of key/mode vectors, scoreboard of
// per-round subkeys, and hand sequences for ignore/abort/reset/fast rounds.
module tb_des_round_ctrl;
   import des_pkg::*;

   logic        clk = 1'b0;
   logic        reset, start0, start1, decrypt, abort;
   logic [55:0] key_cd;

   logic        ready0, busy0, load0, re0, last0, done0;
   logic [3:0]  idx0;
   logic [55:0] sk0;
   state_t      dbg0;
   logic        ready1, busy1, load1, re1, last1, done1;
   logic [3:0]  idx1;
   logic [55:0] sk1;
   state_t      dbg1;

   des_round_ctrl #(.ROUND_CYCLES(2)) dut0 (
      .clk(clk), .reset(reset), .start(start0), .decrypt(decrypt), .key_cd(key_cd),
      .abort(abort), .ready(ready0), .busy(busy0), .load_data(load0), .round_en(re0),
      .round_idx(idx0), .last_round(last0), .subkey_cd(sk0), .done(done0), .dbg_state(dbg0)
   );

   des_round_ctrl #(.ROUND_CYCLES(1)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .decrypt(decrypt), .key_cd(key_cd),
      .abort(abort), .ready(ready1), .busy(busy1), .load_data(load1), .round_en(re1),
      .round_idx(idx1), .last_round(last1), .subkey_cd(sk1), .done(done1), .dbg_state(dbg1)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   int          n_pass = 0, n_total = 0;
   logic [59:0] exp_q[$];
   logic [55:0] sk_log[$];
   logic [59:0] mon_e;
   int          t0 = 0;
   int          done_cnt = 0;
   bit          mon_en = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // ---------------- reference model ----------------
   function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
      logic [55:0] t;
      t = {x, x} << (n % 28);
      return t[55:28];
   endfunction

   // Encrypt round r uses the cumulative left shift; decrypt runs the list backwards.
   function automatic logic [55:0] model_sk(input logic [55:0] key, input bit dec, input int r);
      int sh[16];
      int rr, total;
      sh = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
      rr = dec ? 15 - r : r;
      total = 0;
      for (int i = 0; i <= rr; i++) total += sh[i];
      return {rotl28(key[55:28], total), rotl28(key[27:0], total)};
   endfunction

   // ---------------- monitor for dut0 ----------------
   always @(negedge clk) begin
      if (mon_en) begin
         if (start0 && ready0 && !reset) t0 = cyc;
         if (load0) check("load_lat", cyc - t0, 1);
         if (re0) begin
            if (exp_q.size() == 0) begin
               check("round_en_unexpected", 1, 0);
            end else begin
               mon_e = exp_q.pop_front();
               check("round_idx", idx0, mon_e[59:56]);
               check("subkey", sk0, mon_e[55:0]);
               check("round_lat", cyc - t0, 1 + 2 * (mon_e[59:56] + 1));
               check("last_round", last0, mon_e[59:56] == 4'd15);
            end
            sk_log.push_back(sk0);
         end
         if (done0) begin
            done_cnt++;
            check("done_lat", cyc - t0, 34);
            check("busy_in_done", busy0, 1);
         end
      end
   end

   // ---------------- driver tasks (called at posedge+1) ----------------
   task automatic start_op(input bit dec, input logic [55:0] key, input bit ab);
      decrypt = dec;
      key_cd  = key;
      start0  = 1'b1;
      abort   = ab;
      for (int r = 0; r < 16; r++) exp_q.push_back({4'(r), model_sk(key, dec, r)});
      @(posedge clk); #1;
      start0 = 1'b0;
      abort  = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit seen;
      seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (done0) seen = 1;
      end
      check({name, "_done_seen"}, seen, 1);
      @(posedge clk); #1;
      check({name, "_ready_back"}, ready0, 1);
   endtask

   task automatic check_reset_vals(input string name);
      check({name, "_ready"}, ready0, 1);
      check({name, "_busy"}, busy0, 0);
      check({name, "_load"}, load0, 0);
      check({name, "_round_en"}, re0, 0);
      check({name, "_done"}, done0, 0);
      check({name, "_last"}, last0, 0);
      check({name, "_idx"}, idx0, 0);
      check({name, "_subkey"}, sk0, 0);
      check({name, "_state"}, dbg0, IDLE);
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      bit          dec;
      logic [27:0] c, d;
      logic [27:0] c0, c1, c2, c15;
      logic [55:0] fin;
   } vec_t;

   vec_t vecs[4];
   int   dc;

   initial begin
      vecs[0] = '{0, 28'h0000001, 28'h0000001, 28'h0000002, 28'h0000004, 28'h0000010,
                  28'h0000001, {28'h0000001, 28'h0000001}};
      vecs[1] = '{1, 28'h0000001, 28'h0000001, 28'h0000001, 28'h8000000, 28'h2000000,
                  28'h0000002, {28'h0000002, 28'h0000002}};
      vecs[2] = '{0, 28'h8000000, 28'h0000000, 28'h0000001, 28'h0000002, 28'h0000008,
                  28'h8000000, {28'h8000000, 28'h0000000}};
      vecs[3] = '{1, 28'h0000003, 28'h0000001, 28'h0000003, 28'h8000001, 28'h6000000,
                  28'h0000006, {28'h0000006, 28'h0000002}};

      reset = 1'b1; start0 = 0; start1 = 0; decrypt = 0; abort = 0; key_cd = '0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals("init");
      check("init_rc1_ready", ready1, 1);
      check("init_rc1_subkey", sk1, 0);
      reset = 1'b0;
      mon_en = 1;

      // Table: encrypt/decrypt key orders
      foreach (vecs[v]) begin
         sk_log.delete();
         start_op(vecs[v].dec, {vecs[v].c, vecs[v].d}, 0);
         wait_done($sformatf("vec%0d", v));
         check($sformatf("vec%0d_rounds", v), sk_log.size(), 16);
         if (sk_log.size() == 16) begin
            check($sformatf("vec%0d_c0", v), sk_log[0][55:28], vecs[v].c0);
            check($sformatf("vec%0d_c1", v), sk_log[1][55:28], vecs[v].c1);
            check($sformatf("vec%0d_c2", v), sk_log[2][55:28], vecs[v].c2);
            check($sformatf("vec%0d_c15", v), sk_log[15][55:28], vecs[v].c15);
         end
         check($sformatf("vec%0d_final", v), sk0, vecs[v].fin);
      end

      // start while busy is ignored
      dc = done_cnt;
      start_op(0, {28'h0000001, 28'h0000001}, 0);
      repeat (9) @(posedge clk);
      #1;
      decrypt = 1; key_cd = {28'hABCDEF1, 28'h1234567}; start0 = 1;
      @(posedge clk); #1;
      start0 = 0; decrypt = 0;
      wait_done("ignore");
      repeat (5) @(posedge clk);
      #1;
      check("ignore_done_count", done_cnt - dc, 1);
      check("ignore_q_empty", exp_q.size(), 0);
      check("ignore_final", sk0, {28'h0000001, 28'h0000001});

      // abort at T+12 then restart at T+13
      dc = done_cnt;
      start_op(0, {28'h00F0F0F, 28'h0A0A0A0}, 0);
      repeat (11) @(posedge clk);
      #1;
      abort = 1;
      @(posedge clk); #1;
      abort = 0;
      check("abort12_q_left", exp_q.size(), 11);
      check("abort12_ready", ready0, 1);
      check("abort12_state", dbg0, IDLE);
      exp_q.delete();
      start_op(1, {28'h1357924, 28'h0FEDCBA}, 0);
      wait_done("restart");
      check("restart_done_count", done_cnt - dc, 1);

      // abort on a round commit cycle suppresses that round_en
      dc = done_cnt;
      start_op(1, {28'h5555555, 28'hAAAAAAA}, 0);
      repeat (10) @(posedge clk);
      #1;
      abort = 1;
      @(posedge clk); #1;
      abort = 0;
      check("abort11_q_left", exp_q.size(), 12);
      exp_q.delete();
      repeat (30) @(posedge clk);
      #1;
      check("abort11_no_done", done_cnt - dc, 0);

      // abort in IDLE with start: still accepted
      dc = done_cnt;
      start_op(0, {28'h0000101, 28'h8000001}, 1);
      wait_done("idle_abort");
      check("idle_abort_done_count", done_cnt - dc, 1);

      // reset mid-operation at T+20
      dc = done_cnt;
      start_op(0, {28'h7654321, 28'h0123456}, 0);
      repeat (19) @(posedge clk);
      #1;
      reset = 1;
      @(posedge clk); #1;
      reset = 0;
      check_reset_vals("midreset");
      exp_q.delete();
      repeat (40) @(posedge clk);
      #1;
      check("midreset_no_done", done_cnt - dc, 0);
      start_op(0, {28'h7654321, 28'h0123456}, 0);
      wait_done("post_reset");
      check("post_reset_done_count", done_cnt - dc, 1);

      // ROUND_CYCLES=1 instance
      decrypt = 0; key_cd = {28'h0000001, 28'h0000001}; start1 = 1;
      @(posedge clk); #1;
      start1 = 0;
      for (int rel = 1; rel <= 19; rel++) begin
         @(negedge clk);
         check($sformatf("rc1_load_%0d", rel), load1, rel == 1);
         check($sformatf("rc1_round_en_%0d", rel), re1, rel >= 2 && rel <= 17);
         check($sformatf("rc1_done_%0d", rel), done1, rel == 18);
         if (rel >= 2 && rel <= 17) begin
            check($sformatf("rc1_idx_%0d", rel), idx1, rel - 2);
            check($sformatf("rc1_subkey_%0d", rel), sk1,
                  model_sk({28'h0000001, 28'h0000001}, 0, rel - 2));
         end
      end
      check("rc1_ready_back", ready1, 1);
      @(posedge clk); #1;

      check("final_q_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
